// File: rtl/frame_write_scheduler.sv
// Paces DRAM burst writes of captured frames into a ring of fixed-stride slots.
// Define FWS_CONTINUOUS_EN to capture frames back-to-back until abort.
module frame_write_scheduler #(
   parameter int                       DRAM_ADDR_LEN  = 32,
   parameter logic [DRAM_ADDR_LEN-1:0] DRAM_ADDR_BASE = 32'h8000_0000,
   parameter int                       BEAT_BYTES     = 16,
   parameter int                       BURST_BEATS    = 32,
   parameter logic [DRAM_ADDR_LEN-1:0] FRAME_STRIDE   = 32'h0020_0000,
   parameter int                       NUM_FRAMES     = 4,
   parameter int                       LEVEL_WIDTH    = 10
) (
   input  logic                           s_axi_aclk,
   input  logic                           s_axi_aresetn,
   input  logic                           arm,
   input  logic                           abort,
   input  logic                           fval,
   input  logic [LEVEL_WIDTH-1:0]         fifo_level,
   output logic                           wr_req,
   output logic [DRAM_ADDR_LEN-1:0]       wr_addr,
   output logic [7:0]                     wr_len,
   input  logic                           wr_ack,
   input  logic                           wr_done,
   input  logic                           wr_err,
   output logic                           busy,
   output logic [$clog2(NUM_FRAMES)-1:0]  frame_index,
   output logic                           image_end,
   output logic                           overrun,
   output logic                           error
);

   localparam int FI_W       = $clog2(NUM_FRAMES);
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

   typedef logic [DRAM_ADDR_LEN-1:0] addr_t;

   localparam addr_t           BURST_A = addr_t'(BURST_BEATS);
   localparam logic [FI_W-1:0] FI_LAST = FI_W'(NUM_FRAMES - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SOF,
      STREAM,
      ISSUE,
      WAIT_DONE,
      DRAIN,
      FRAME_END
   } state_t;

   state_t          state;
   state_t          state_d;
   logic            fval_q;
   logic            abort_q;
   logic            abort_d;
   addr_t           offset;
   addr_t           offset_d;
   logic [8:0]      beats;
   logic [8:0]      beats_d;
   logic            req_d;
   addr_t           addr_d;
   logic [7:0]      len_d;
   logic            busy_d;
   logic            ie_d;
   logic            ovr_d;
   logic            err_d;
   logic [FI_W-1:0] fi_d;

   addr_t base;
   addr_t remain;
   addr_t lvl;
   addr_t want;
   addr_t clip;
   addr_t step;

   // Burst sizing: full burst when available, otherwise the FIFO
   // residue, never running past the end of the current slot.
   always_comb begin
      base   = DRAM_ADDR_BASE + addr_t'(frame_index) * FRAME_STRIDE;
      remain = (FRAME_STRIDE - offset) >> BEAT_SHIFT;
      lvl    = addr_t'(fifo_level);
      want   = (lvl >= BURST_A) ? BURST_A : lvl;
      clip   = (want > remain) ? remain : want;
      step   = addr_t'(beats) << BEAT_SHIFT;
   end

   always_comb begin
      state_d  = state;
      abort_d  = abort_q;
      offset_d = offset;
      beats_d  = beats;
      ovr_d    = overrun;
      err_d    = error;
      fi_d     = frame_index;
      addr_d   = wr_addr;
      len_d    = wr_len;

      unique case (state)
         IDLE: begin
            abort_d = 1'b0;
            if (arm && !abort) begin
               state_d = WAIT_SOF;
               ovr_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         WAIT_SOF: begin
            if (abort) begin
               state_d = IDLE;
            end else if (fval && !fval_q) begin
               state_d  = STREAM;
               offset_d = '0;
            end
         end
         STREAM: begin
            if (abort) begin
               state_d = IDLE;
            end else if (offset == FRAME_STRIDE) begin
               state_d = DRAIN;
               ovr_d   = 1'b1;
            end else if (lvl >= BURST_A || (!fval && lvl != '0)) begin
               state_d = ISSUE;
               beats_d = 9'(clip);
               addr_d  = base + offset;
               len_d   = 8'(clip - 1'b1);
            end else if (!fval) begin
               state_d = FRAME_END;
            end
         end
         ISSUE: begin
            if (wr_ack) begin
               state_d = WAIT_DONE;
               abort_d = abort;
            end else if (abort) begin
               state_d = IDLE;
            end
         end
         WAIT_DONE: begin
            if (abort) begin
               abort_d = 1'b1;
            end
            if (wr_done) begin
               offset_d = offset + step;
               if (wr_err) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end else if (abort_q || abort) begin
                  state_d = IDLE;
               end else begin
                  state_d = STREAM;
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (!fval) begin
               state_d = FRAME_END;
            end
         end
         FRAME_END: begin
            fi_d = (frame_index == FI_LAST) ? '0 : frame_index + 1'b1;
`ifdef FWS_CONTINUOUS_EN
            state_d = abort ? IDLE : WAIT_SOF;
`else
            state_d = IDLE;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_d  = (state_d == ISSUE);
      busy_d = (state_d != IDLE);
      ie_d   = (state_d == FRAME_END);
   end

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         state       <= IDLE;
         fval_q      <= 1'b0;
         abort_q     <= 1'b0;
         offset      <= '0;
         beats       <= '0;
         wr_req      <= 1'b0;
         wr_addr     <= DRAM_ADDR_BASE;
         wr_len      <= '0;
         busy        <= 1'b0;
         frame_index <= '0;
         image_end   <= 1'b0;
         overrun     <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= state_d;
         fval_q      <= fval;
         abort_q     <= abort_d;
         offset      <= offset_d;
         beats       <= beats_d;
         wr_req      <= req_d;
         wr_addr     <= addr_d;
         wr_len      <= len_d;
         busy        <= busy_d;
         frame_index <= fi_d;
         image_end   <= ie_d;
         overrun     <= ovr_d;
         error       <= err_d;
      end
   end

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Directed scoreboard bench for frame_write_scheduler: default slots on one
// instance, a two-burst slot on a second instance to reach the overrun path.
module tb_frame_write_scheduler;

`ifdef FWS_CONTINUOUS_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
   } req_t;

   logic clk = 1'b0;
   logic rst_n;
   logic arm_a;
   logic arm_b;
   logic abort;
   logic fval;
   logic [9:0] fifo_level;

   logic        a_req;
   logic [31:0] a_addr;
   logic [7:0]  a_len;
   logic        a_ack  = 1'b0;
   logic        a_done = 1'b0;
   logic        a_err  = 1'b0;
   logic        a_busy;
   logic [1:0]  a_fi;
   logic        a_ie;
   logic        a_ovr;
   logic        a_error;

   logic        b_req;
   logic [31:0] b_addr;
   logic [7:0]  b_len;
   logic        b_ack  = 1'b0;
   logic        b_done = 1'b0;
   logic        b_err  = 1'b0;
   logic        b_busy;
   logic [0:0]  b_fi;
   logic        b_ie;
   logic        b_ovr;
   logic        b_error;

   int fifo_in  = 0;
   int a_out    = 0;
   int b_out    = 0;
   int a_bursts = 0;
   int b_bursts = 0;
   int a_ie_cnt = 0;
   int b_ie_cnt = 0;
   int err_at   = -1;
   int n_vec    = 0;
   int n_err    = 0;

   req_t exp_a[$];
   req_t exp_b[$];

   assign fifo_level = 10'(fifo_in - a_out - b_out);

   always #5 clk = ~clk;

   frame_write_scheduler u_a (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .arm           (arm_a),
      .abort         (abort),
      .fval          (fval),
      .fifo_level    (fifo_level),
      .wr_req        (a_req),
      .wr_addr       (a_addr),
      .wr_len        (a_len),
      .wr_ack        (a_ack),
      .wr_done       (a_done),
      .wr_err        (a_err),
      .busy          (a_busy),
      .frame_index   (a_fi),
      .image_end     (a_ie),
      .overrun       (a_ovr),
      .error         (a_error)
   );

   frame_write_scheduler #(
      .FRAME_STRIDE (32'h0000_0400),
      .NUM_FRAMES   (2)
   ) u_b (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .arm           (arm_b),
      .abort         (abort),
      .fval          (fval),
      .fifo_level    (fifo_level),
      .wr_req        (b_req),
      .wr_addr       (b_addr),
      .wr_len        (b_len),
      .wr_ack        (b_ack),
      .wr_done       (b_done),
      .wr_err        (b_err),
      .busy          (b_busy),
      .frame_index   (b_fi),
      .image_end     (b_ie),
      .overrun       (b_ovr),
      .error         (b_error)
   );

   // Write-engine stand-ins: ack one cycle, B response four cycles later.
   initial begin
      forever begin
         @(negedge clk);
         if (a_req) begin
            a_ack = 1'b1;
            a_out += int'(a_len) + 1;
            a_bursts++;
            @(negedge clk);
            a_ack = 1'b0;
            repeat (3) @(negedge clk);
            a_err  = (a_bursts == err_at);
            a_done = 1'b1;
            @(negedge clk);
            a_done = 1'b0;
            a_err  = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (b_req) begin
            b_ack = 1'b1;
            b_out += int'(b_len) + 1;
            b_bursts++;
            @(negedge clk);
            b_ack = 1'b0;
            repeat (3) @(negedge clk);
            b_done = 1'b1;
            @(negedge clk);
            b_done = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (a_ie) a_ie_cnt++;
         if (b_ie) b_ie_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [39:0] obs,
                      input logic [39:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit sel_b, input logic [31:0] addr,
                       input logic [7:0] len);
      req_t e;
      e.addr = addr;
      e.len  = len;
      if (sel_b) exp_b.push_back(e);
      else exp_a.push_back(e);
   endtask

   task automatic expect_req(input bit sel_b, input string tag);
      req_t e;
      int   i;
      e = sel_b ? exp_b.pop_front() : exp_a.pop_front();
      i = 0;
      while (!(sel_b ? b_req : a_req) && i < 400) begin
         @(negedge clk);
         i++;
      end
      chk({tag, "_req"}, sel_b ? b_req : a_req, 1);
      chk({tag, "_addr"}, sel_b ? b_addr : a_addr, e.addr);
      chk({tag, "_len"}, sel_b ? b_len : a_len, e.len);
      while ((sel_b ? b_req : a_req) && i < 400) begin
         @(negedge clk);
         i++;
      end
   endtask

   task automatic wait_ie(input bit sel_b, input int target);
      for (int i = 0; i < 400; i++) begin
         if ((sel_b ? b_ie_cnt : a_ie_cnt) >= target) break;
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic pulse_arm(input bit sel_b);
      if (sel_b) arm_b = 1'b1;
      else arm_a = 1'b1;
      @(negedge clk);
      arm_a = 1'b0;
      arm_b = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic flush();
      fval    = 1'b0;
      fifo_in = a_out + b_out;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      arm_a = 1'b0;
      arm_b = 1'b0;
      abort = 1'b0;
      fval  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", a_req, 0);
      chk("rst_addr", a_addr, 32'h8000_0000);
      chk("rst_len", a_len, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_fi", a_fi, 0);
      chk("rst_ie", a_ie, 0);
      chk("rst_ovr", a_ovr, 0);
      chk("rst_err", a_error, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // four full bursts, frame ends on an empty FIFO
      pulse_arm(0);
      chk("f1_busy", a_busy, 1);
      for (int k = 0; k < 4; k++)
         push(0, 32'h8000_0000 + 32'(k) * 32'h200, 8'd31);
      fval = 1'b1;
      fifo_in += 128;
      for (int k = 0; k < 4; k++) expect_req(0, "f1");
      fval = 1'b0;
      wait_ie(0, 1);
      @(negedge clk);
      chk("f1_ie_cnt", a_ie_cnt, 1);
      chk("f1_fi", a_fi, 1);
      chk("f1_busy_end", a_busy, CONT);
      chk("f1_ovr", a_ovr, 0);
      pulse_abort();
      chk("f1_idle", a_busy, 0);

      // two full bursts then a five-beat tail into slot 1
      pulse_arm(0);
      push(0, 32'h8020_0000, 8'd31);
      push(0, 32'h8020_0200, 8'd31);
      push(0, 32'h8020_0400, 8'd4);
      fval = 1'b1;
      fifo_in += 64;
      expect_req(0, "f2a");
      expect_req(0, "f2b");
      fval = 1'b0;
      fifo_in += 5;
      expect_req(0, "f2tail");
      wait_ie(0, 2);
      @(negedge clk);
      chk("f2_ie_cnt", a_ie_cnt, 2);
      chk("f2_fi", a_fi, 2);
      pulse_abort();
      flush();

      // SLVERR on the second burst
      err_at = a_bursts + 2;
      pulse_arm(0);
      push(0, 32'h8040_0000, 8'd31);
      push(0, 32'h8040_0200, 8'd31);
      fval = 1'b1;
      fifo_in += 96;
      expect_req(0, "er");
      expect_req(0, "er");
      repeat (8) @(negedge clk);
      chk("er_error", a_error, 1);
      chk("er_busy", a_busy, 0);
      chk("er_no_ie", a_ie_cnt, 2);
      chk("er_fi", a_fi, 2);
      chk("er_no_more", a_bursts, err_at);
      err_at = -1;
      flush();

      // abort while a burst is outstanding
      pulse_arm(0);
      chk("ab_err_clr", a_error, 0);
      chk("ab_busy", a_busy, 1);
      push(0, 32'h8040_0000, 8'd31);
      fval = 1'b1;
      fifo_in += 64;
      expect_req(0, "ab");
      pulse_abort();
      chk("ab_held", a_busy, 1);
      for (int i = 0; i < 30 && a_busy; i++) @(negedge clk);
      chk("ab_idle", a_busy, 0);
      repeat (6) @(negedge clk);
      chk("ab_bursts", a_bursts, 10);
      chk("ab_no_ie", a_ie_cnt, 2);
      chk("ab_req", a_req, 0);
      flush();

      // slot of two bursts, frame carries three
      pulse_arm(1);
      push(1, 32'h8000_0000, 8'd31);
      push(1, 32'h8000_0200, 8'd31);
      fval = 1'b1;
      fifo_in += 96;
      expect_req(1, "ov");
      expect_req(1, "ov");
      repeat (10) @(negedge clk);
      chk("ov_flag", b_ovr, 1);
      chk("ov_busy", b_busy, 1);
      chk("ov_no_ie", b_ie_cnt, 0);
      chk("ov_bursts", b_bursts, 2);
      fval = 1'b0;
      wait_ie(1, 1);
      @(negedge clk);
      chk("ov_ie_cnt", b_ie_cnt, 1);
      chk("ov_fi", b_fi, 1);
      chk("ov_busy_end", b_busy, CONT);
      chk("ov_err", b_error, 0);
      pulse_abort();
      flush();
      chk("ov_sticky", b_ovr, 1);
      pulse_arm(1);
      chk("ov_clr", b_ovr, 0);
      pulse_abort();

`ifdef FWS_CONTINUOUS_EN
      // ring wrap across five back-to-back frames
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("c_rst_fi", a_fi, 0);
      chk("c_rst_busy", a_busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      begin
         int ie0;
         ie0 = a_ie_cnt;
         pulse_arm(0);
         for (int f = 0; f < 5; f++) begin
            push(0, 32'h8000_0000 + 32'(f % 4) * 32'h0020_0000, 8'd31);
            fval = 1'b1;
            fifo_in += 32;
            expect_req(0, "cf");
            fval = 1'b0;
            wait_ie(0, ie0 + f + 1);
         end
         chk("c_ie_cnt", a_ie_cnt, ie0 + 5);
         chk("c_busy", a_busy, 1);
         chk("c_fi", a_fi, 1);
      end
      pulse_abort();
      chk("c_idle", a_busy, 0);
      flush();
`endif

      chk("q_a_empty", exp_a.size(), 0);
      chk("q_b_empty", exp_b.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/frame_write_scheduler.md
# frame_write_scheduler

Sequences the Camera Link capture path's DRAM writes. It watches the pixel FIFO fill level and the frame-valid flag, and issues one burst request at a time to the AXI write engine. Each frame is placed in a ring of fixed-stride frame slots starting at `DRAM_ADDR_BASE`. It runs in the `s_axi_aclk` domain, between the clock-crossing pixel FIFO and the m_axi write master, and drives `image_end`.

## Interface
- `DRAM_ADDR_LEN`, 32: address width.
- `DRAM_ADDR_BASE`, 32'h8000_0000: byte address of frame slot 0.
- `BEAT_BYTES`, 16: bytes per write beat (128-bit data).
- `BURST_BEATS`, 32: full burst length (512 B).
- `FRAME_STRIDE`, 32'h0020_0000: bytes per frame slot; a multiple of `BURST_BEATS*BEAT_BYTES`.
- `NUM_FRAMES`, 4: ring depth, ≥2.
- `LEVEL_WIDTH`, 10: FIFO level width.

Ports:
- `s_axi_aclk` in 1: the block's single clock.
- `s_axi_aresetn` in 1: reset, synchronous and active-low.
- `arm` in 1: one-cycle pulse; starts capture.
- `abort` in 1: one-cycle pulse; returns to IDLE after any in-flight burst.
- `fval` in 1: frame valid, already synchronized to `s_axi_aclk`.
- `fifo_level` in LEVEL_WIDTH: beats readable from the pixel FIFO.
- `wr_req` out 1: burst request valid.
- `wr_addr` out DRAM_ADDR_LEN: burst byte address.
- `wr_len` out 8: beats−1 (AXI awlen encoding).
- `wr_ack` in 1: request accepted.
- `wr_done` in 1: burst's B response received.
- `wr_err` in 1: B response was SLVERR/DECERR; qualified by `wr_done`.
- `busy` out 1: not IDLE.
- `frame_index` out $clog2(NUM_FRAMES): slot currently or last written.
- `image_end` out 1: one-cycle pulse when a frame's last burst completes.
- `overrun` out 1: sticky; the frame exceeded `FRAME_STRIDE`.
- `error` out 1: sticky; `wr_err` was seen.

## Operation
States:
- IDLE: `arm` → WAIT_SOF. Clears `overrun` and `error`.
- WAIT_SOF: waits for a `fval` rising edge (`fval & ~fval_q`) → STREAM, with `offset` = 0. A `fval` already high at arm is ignored until it falls and rises again.
- STREAM: decides once per cycle, in priority order:
  - (a) `offset` == `FRAME_STRIDE` → set `overrun`, go to DRAIN.
  - (b) `fifo_level` ≥ `BURST_BEATS` → ISSUE with n = `BURST_BEATS`.
  - (c) `fval`==0 and `fifo_level` > 0 → ISSUE with n = `fifo_level` (partial flush).
  - (d) `fval`==0 and `fifo_level`==0 → FRAME_END.
- ISSUE: `wr_req`=1; `wr_addr` = base(frame_index) + offset; `wr_len` = n−1. On `wr_ack` → WAIT_DONE.
- WAIT_DONE: on `wr_done`, `offset` += n*`BEAT_BYTES`.
  - If `wr_err`: set `error`, go to IDLE, no `image_end`.
  - Otherwise go to STREAM.
- DRAIN: no requests; waits for `fval`==0 → FRAME_END. The FIFO is not drained; the upstream FIFO reset handles that.
- FRAME_END: pulse `image_end`; `frame_index` ← (frame_index == NUM_FRAMES−1) ? 0 : frame_index+1; then IDLE (see Configuration).

Rules:
- base(i) = `DRAM_ADDR_BASE` + i*`FRAME_STRIDE`, computed modulo 2^DRAM_ADDR_LEN.
- A partial burst is clipped to `FRAME_STRIDE` − offset beats-worth when it would cross the slot end.
- Only one burst is outstanding at any time.
- `abort`:
  - In IDLE, WAIT_SOF, STREAM or DRAIN → IDLE on the next cycle.
  - In ISSUE → IDLE only if `wr_ack` has not been seen, with `wr_req` dropped.
  - In WAIT_DONE → latched, then taken at `wr_done`.
  - No `image_end` on abort.
- `arm` outside IDLE is ignored.

## Timing
- Reset values: `wr_req`=0, `wr_addr`=`DRAM_ADDR_BASE`, `wr_len`=0, `busy`=0, `frame_index`=0, `image_end`=0, `overrun`=0, `error`=0. `fval_q`=0. State IDLE.
- All outputs are registered.
- `fval` rise at cycle t → STREAM at t+1 → earliest `wr_req` at t+2.
- `wr_addr`/`wr_len` are stable while `wr_req`=1.
- `wr_req` falls the cycle after `wr_ack`.
- `wr_ack` in the same cycle that `wr_req` rises is legal.
- `wr_done` → STREAM next cycle; `fifo_level` is re-sampled there, so the FIFO's one-cycle level latency is tolerated.
- `image_end` is high exactly one cycle, in FRAME_END.
- In WAIT_DONE, `wr_done` and `abort` in the same cycle → IDLE, with `offset` updated.
- Reset mid-burst: outputs return to reset values next edge; the write engine is reset by the same `s_axi_aresetn`.

## Configuration
- `FWS_CONTINUOUS_EN` defined: FRAME_END goes to WAIT_SOF rather than IDLE, so frames are captured back-to-back into the ring until `abort`; `busy` stays 1.
- Undefined: one frame per `arm`.

## Test plan
- Arm, `fval` high for 4 bursts (`fifo_level` 32 each), `fval` low with level 0 → 4 requests at 0x8000_0000/+0x200/+0x400/+0x600, `wr_len`=31, one `image_end`, `frame_index`=1.
- Frame ends with `fifo_level`=5 → final request `wr_len`=4 at the next offset, then `image_end`.
- `FRAME_STRIDE`=0x400, frame of 3 full bursts → 2 bursts issued, `overrun`=1, `image_end` after `fval` falls.
- `wr_done` with `wr_err`=1 on burst 2 → `error`=1, IDLE, no `image_end`, `busy`=0.
- `FWS_CONTINUOUS_EN`, 5 frames, `NUM_FRAMES`=4 → frame 5 based at 0x8000_0000; `abort` during WAIT_DONE → IDLE only after `wr_done`.
